// File: rtl/simt_reconv_stack_mw_pkg.sv
// Shared defaults and helpers for the multi-warp SIMT reconvergence stack.
// An entry is stored packed as {rpc, jpc, mask}, ENTRY_W bits wide.
package simt_reconv_stack_mw_pkg;
  localparam int DEF_NUM_WARP   = 4;
  localparam int DEF_NUM_THREAD = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_PC_WIDTH   = 32;
  localparam int ENTRY_W        = 2 * DEF_PC_WIDTH + DEF_NUM_THREAD;

  // Index width that stays legal when the indexed set has a single element.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/simt_reconv_stack_mw_if.sv
// Request/response/status bundle of the reconvergence stack.
// master drives requests; slave is the stack itself.
interface simt_reconv_stack_mw_if
  import simt_reconv_stack_mw_pkg::*;
#(
  parameter int NUM_WARP   = DEF_NUM_WARP,
  parameter int NUM_THREAD = DEF_NUM_THREAD,
  parameter int PC_WIDTH   = DEF_PC_WIDTH
);
  localparam int WID_W = clog2_min1(NUM_WARP);

  logic                  push_i;
  logic [WID_W-1:0]      push_wid_i;
  logic [PC_WIDTH-1:0]   push_recon_pc_i;
  logic [PC_WIDTH-1:0]   push_jump_pc_i;
  logic [NUM_THREAD-1:0] push_new_mask_i;
  logic [NUM_THREAD-1:0] push_thread_mask_i;
  logic                  pop_i;
  logic [WID_W-1:0]      pop_wid_i;
  logic [PC_WIDTH-1:0]   pc_execute_i;
  logic                  flush_i;
  logic [WID_W-1:0]      flush_wid_i;
  logic                  resp_valid_o;
  logic [WID_W-1:0]      resp_wid_o;
  logic                  resp_jump_o;
  logic [PC_WIDTH-1:0]   resp_pc_o;
  logic [NUM_THREAD-1:0] resp_mask_o;
  logic [NUM_WARP-1:0]   empty_o;
  logic [NUM_WARP-1:0]   full_o;
  logic [NUM_WARP-1:0]   overflow_o;

  modport master (
    output push_i, push_wid_i, push_recon_pc_i, push_jump_pc_i, push_new_mask_i,
           push_thread_mask_i, pop_i, pop_wid_i, pc_execute_i, flush_i, flush_wid_i,
    input  resp_valid_o, resp_wid_o, resp_jump_o, resp_pc_o, resp_mask_o,
           empty_o, full_o, overflow_o
  );

  modport slave (
    input  push_i, push_wid_i, push_recon_pc_i, push_jump_pc_i, push_new_mask_i,
           push_thread_mask_i, pop_i, pop_wid_i, pc_execute_i, flush_i, flush_wid_i,
    output resp_valid_o, resp_wid_o, resp_jump_o, resp_pc_o, resp_mask_o,
           empty_o, full_o, overflow_o
  );
endinterface

// File: rtl/simt_reconv_stack_mw_bank.sv
// One warp's divergence stack: storage, stack pointer, overflow flag, TOS match.
// Requests arrive already arbitrated; at most one of push/pop/flush acts per edge.
module simt_reconv_stack_mw_bank
  import simt_reconv_stack_mw_pkg::*;
#(
  parameter int NUM_THREAD = DEF_NUM_THREAD,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   recon_pc,
  input  logic [PC_WIDTH-1:0]   jump_pc,
  input  logic [NUM_THREAD-1:0] new_mask,
  input  logic [NUM_THREAD-1:0] thread_mask,
  input  logic [PC_WIDTH-1:0]   pc_execute,
  output logic                  tos_hit,
  output logic [PC_WIDTH-1:0]   tos_jpc,
  output logic [NUM_THREAD-1:0] tos_mask,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = clog2_min1(DEPTH);
  localparam int EW    = 2 * PC_WIDTH + NUM_THREAD;

  logic [SP_W-1:0]  sp_r;
  logic             ovf_r;
  logic [EW-1:0]    mem_r [DEPTH];
  logic             room_s;
  logic [IDX_W-1:0] tos_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] wr_idx1_s;
  logic [EW-1:0]    tos_s;

  // Top-of-stack read, match against the executing PC, and status flags.
  always_comb begin
    room_s    = (sp_r <= SP_W'(DEPTH - 2));
    wr_idx_s  = sp_r[IDX_W-1:0];
    wr_idx1_s = wr_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
    if (sp_r != {SP_W{1'b0}}) begin
      tos_idx_s = IDX_W'(sp_r - {{(SP_W-1){1'b0}}, 1'b1});
    end else begin
      tos_idx_s = {IDX_W{1'b0}};
    end
    tos_s    = mem_r[tos_idx_s];
    tos_hit  = (sp_r != {SP_W{1'b0}}) && (tos_s[EW-1 -: PC_WIDTH] == pc_execute);
    tos_jpc  = tos_s[NUM_THREAD +: PC_WIDTH];
    tos_mask = tos_s[NUM_THREAD-1:0];
    empty    = (sp_r == {SP_W{1'b0}});
    full     = !room_s;
    overflow = ovf_r;
  end

  // Stack pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r  <= {SP_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (flush) begin
      sp_r  <= {SP_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (push) begin
      if (room_s) begin
        sp_r <= sp_r + SP_W'(2);
      end else begin
        ovf_r <= 1'b1;
      end
    end else if (pop && tos_hit) begin
      sp_r <= sp_r - {{(SP_W-1){1'b0}}, 1'b1};
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage: join entry below, taken-path entry on top.
  always_ff @(posedge clk) begin
    if (push && !flush && room_s) begin
      mem_r[wr_idx_s]  <= {recon_pc, recon_pc, thread_mask};
      mem_r[wr_idx1_s] <= {recon_pc, jump_pc, new_mask};
    end
  end
endmodule

// File: rtl/simt_reconv_stack_mw.sv
// Multi-warp SIMT divergence/reconvergence stack: per-warp banks, same-warp
// arbitration (flush > push > pop) and a registered pop response.
module simt_reconv_stack_mw
  import simt_reconv_stack_mw_pkg::*;
#(
  parameter int NUM_WARP   = DEF_NUM_WARP,
  parameter int NUM_THREAD = DEF_NUM_THREAD,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
  input logic                  clk,
  input logic                  rst_n,
  simt_reconv_stack_mw_if.slave bus
);
  localparam int WID_W = clog2_min1(NUM_WARP);

  logic [NUM_WARP-1:0]   flush_s;
  logic [NUM_WARP-1:0]   push_s;
  logic [NUM_WARP-1:0]   pop_s;
  logic                  hit_s   [NUM_WARP];
  logic [PC_WIDTH-1:0]   jpc_s   [NUM_WARP];
  logic [NUM_THREAD-1:0] mask_s  [NUM_WARP];
  logic                  empty_s [NUM_WARP];
  logic                  full_s  [NUM_WARP];
  logic                  ovf_s   [NUM_WARP];
  logic [NUM_WARP-1:0]   empty_v_s;
  logic [NUM_WARP-1:0]   full_v_s;
  logic [NUM_WARP-1:0]   ovf_v_s;
  logic                  jump_s;
  logic                  resp_valid_r;
  logic [WID_W-1:0]      resp_wid_r;
  logic                  resp_jump_r;
  logic [PC_WIDTH-1:0]   resp_pc_r;
  logic [NUM_THREAD-1:0] resp_mask_r;

  // Warp-id decode with same-warp priority, and status vector packing.
  always_comb begin
    for (int w = 0; w < NUM_WARP; w++) begin
      flush_s[w]   = bus.flush_i && (bus.flush_wid_i == WID_W'(w));
      push_s[w]    = bus.push_i && (bus.push_wid_i == WID_W'(w)) && !flush_s[w];
      pop_s[w]     = bus.pop_i && (bus.pop_wid_i == WID_W'(w)) && !flush_s[w] && !push_s[w];
      empty_v_s[w] = empty_s[w];
      full_v_s[w]  = full_s[w];
      ovf_v_s[w]   = ovf_s[w];
    end
    jump_s = pop_s[bus.pop_wid_i] && hit_s[bus.pop_wid_i];
  end

  for (genvar g = 0; g < NUM_WARP; g++) begin : g_bank
    simt_reconv_stack_mw_bank #(
      .NUM_THREAD (NUM_THREAD),
      .DEPTH      (DEPTH),
      .PC_WIDTH   (PC_WIDTH)
    ) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push_s[g]),
      .pop         (pop_s[g]),
      .flush       (flush_s[g]),
      .recon_pc    (bus.push_recon_pc_i),
      .jump_pc     (bus.push_jump_pc_i),
      .new_mask    (bus.push_new_mask_i),
      .thread_mask (bus.push_thread_mask_i),
      .pc_execute  (bus.pc_execute_i),
      .tos_hit     (hit_s[g]),
      .tos_jpc     (jpc_s[g]),
      .tos_mask    (mask_s[g]),
      .empty       (empty_s[g]),
      .full        (full_s[g]),
      .overflow    (ovf_s[g])
    );
  end

  // Pop response register: one pulse per pop, redirect fields zero unless jumping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_wid_r   <= {WID_W{1'b0}};
      resp_jump_r  <= 1'b0;
      resp_pc_r    <= {PC_WIDTH{1'b0}};
      resp_mask_r  <= {NUM_THREAD{1'b0}};
    end else if (bus.pop_i) begin
      resp_valid_r <= 1'b1;
      resp_wid_r   <= bus.pop_wid_i;
      resp_jump_r  <= jump_s;
      resp_pc_r    <= jump_s ? jpc_s[bus.pop_wid_i] : {PC_WIDTH{1'b0}};
      resp_mask_r  <= jump_s ? mask_s[bus.pop_wid_i] : {NUM_THREAD{1'b0}};
    end else begin
      resp_valid_r <= 1'b0;
      resp_wid_r   <= {WID_W{1'b0}};
      resp_jump_r  <= 1'b0;
      resp_pc_r    <= {PC_WIDTH{1'b0}};
      resp_mask_r  <= {NUM_THREAD{1'b0}};
    end
  end

  assign bus.resp_valid_o = resp_valid_r;
  assign bus.resp_wid_o   = resp_wid_r;
  assign bus.resp_jump_o  = resp_jump_r;
  assign bus.resp_pc_o    = resp_pc_r;
  assign bus.resp_mask_o  = resp_mask_r;
  assign bus.empty_o      = empty_v_s;
  assign bus.full_o       = full_v_s;
  assign bus.overflow_o   = ovf_v_s;
endmodule

// File: tb/tb_simt_reconv_stack_mw.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the per-warp stacks.
module tb_simt_reconv_stack_mw;
  localparam int NW = 4;
  localparam int DP = 8;

  typedef struct packed {
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [7:0]  mask;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ent_t stk [NW][$];
  bit   ovf [NW];

  simt_reconv_stack_mw_if bus ();

  simt_reconv_stack_mw dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_empty();
    logic [3:0] v;
    for (int w = 0; w < NW; w++) v[w] = (stk[w].size() == 0);
    return v;
  endfunction

  function automatic logic [3:0] exp_full();
    logic [3:0] v;
    for (int w = 0; w < NW; w++) v[w] = (stk[w].size() > DP - 2);
    return v;
  endfunction

  function automatic logic [3:0] exp_ovf();
    logic [3:0] v;
    for (int w = 0; w < NW; w++) v[w] = ovf[w];
    return v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      stk[w].delete();
      ovf[w] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    bus.push_i = 1'b0; bus.push_wid_i = 2'd0; bus.push_recon_pc_i = 32'h0;
    bus.push_jump_pc_i = 32'h0; bus.push_new_mask_i = 8'h0; bus.push_thread_mask_i = 8'h0;
    bus.pop_i = 1'b0; bus.pop_wid_i = 2'd0; bus.pc_execute_i = 32'h0;
    bus.flush_i = 1'b0; bus.flush_wid_i = 2'd0;
  endtask

  // One clock cycle of stimulus, model update, and full output check.
  task automatic step(input bit ps, input logic [1:0] pw, input logic [31:0] rpc,
                      input logic [31:0] jpc, input logic [7:0] nm, input logic [7:0] tm,
                      input bit pp, input logic [1:0] ppw, input logic [31:0] pc,
                      input bit fl, input logic [1:0] fw);
    bit          p_eff, o_eff, e_jump;
    logic [31:0] e_pc;
    logic [7:0]  e_mask;
    ent_t        t;
    bus.push_i = ps; bus.push_wid_i = pw; bus.push_recon_pc_i = rpc;
    bus.push_jump_pc_i = jpc; bus.push_new_mask_i = nm; bus.push_thread_mask_i = tm;
    bus.pop_i = pp; bus.pop_wid_i = ppw; bus.pc_execute_i = pc;
    bus.flush_i = fl; bus.flush_wid_i = fw;
    p_eff  = ps && !(fl && fw == pw);
    o_eff  = pp && !(fl && fw == ppw) && !(p_eff && pw == ppw);
    e_jump = 1'b0; e_pc = 32'h0; e_mask = 8'h0;
    if (o_eff && stk[ppw].size() > 0) begin
      t = stk[ppw][stk[ppw].size() - 1];
      if (t.rpc == pc) begin
        e_jump = 1'b1; e_pc = t.jpc; e_mask = t.mask;
        void'(stk[ppw].pop_back());
      end
    end
    if (fl) begin
      stk[fw].delete();
      ovf[fw] = 1'b0;
    end
    if (p_eff) begin
      if (stk[pw].size() <= DP - 2) begin
        stk[pw].push_back('{rpc: rpc, jpc: rpc, mask: tm});
        stk[pw].push_back('{rpc: rpc, jpc: jpc, mask: nm});
      end else begin
        ovf[pw] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("resp_valid", 64'(bus.resp_valid_o), 64'(pp));
    if (pp) chk("resp_wid", 64'(bus.resp_wid_o), 64'(ppw));
    chk("resp_jump", 64'(bus.resp_jump_o), 64'(e_jump));
    chk("resp_pc", 64'(bus.resp_pc_o), 64'(e_pc));
    chk("resp_mask", 64'(bus.resp_mask_o), 64'(e_mask));
    chk("empty", 64'(bus.empty_o), 64'(exp_empty()));
    chk("full", 64'(bus.full_o), 64'(exp_full()));
    chk("overflow", 64'(bus.overflow_o), 64'(exp_ovf()));
  endtask

  task automatic idle_step();
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    #22;
    chk("rst_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_empty", 64'(bus.empty_o), 64'hF);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pop on an empty warp.
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b1, 2'd0, 32'h100, 1'b0, 2'd0);
    chk("plan_empty_pop", {bus.resp_valid_o, bus.resp_jump_o}, 64'h2);

    // Push w1, then pop taken path and join entry.
    step(1'b1, 2'd1, 32'h200, 32'h180, 8'h0F, 8'hFF, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b1, 2'd1, 32'h200, 1'b0, 2'd0);
    chk("plan_taken_pc", 64'(bus.resp_pc_o), 64'h180);
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b1, 2'd1, 32'h200, 1'b0, 2'd0);
    chk("plan_join", {bus.resp_pc_o, bus.resp_mask_o}, 64'h200FF);
    chk("plan_w1_empty", 64'(bus.empty_o[1]), 64'd1);

    // Fill w2, overflow, TOS preserved, then flush.
    for (int i = 0; i < 5; i++)
      step(1'b1, 2'd2, 32'h500 + 32'(i * 16), 32'h600 + 32'(i), 8'(i + 1), 8'hF0,
           1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
    chk("plan_ovf", {bus.full_o[2], bus.overflow_o[2]}, 64'h3);
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b1, 2'd2, 32'h530, 1'b0, 2'd0);
    chk("plan_tos_kept", 64'(bus.resp_pc_o), 64'h603);
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd2);

    // PC mismatch leaves the stack alone.
    step(1'b1, 2'd0, 32'h300, 32'h280, 8'h33, 8'h77, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b1, 2'd0, 32'h304, 1'b0, 2'd0);

    // Cross-warp concurrency and same-warp suppression.
    step(1'b1, 2'd3, 32'h400, 32'h3C0, 8'h01, 8'h03, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
    step(1'b1, 2'd0, 32'h340, 32'h320, 8'h05, 8'h07, 1'b1, 2'd3, 32'h400, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h700, 32'h6C0, 8'h0C, 8'h0E, 1'b1, 2'd1, 32'h700, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h740, 32'h720, 8'h02, 8'h06, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b1, 2'd0, 32'h340, 1'b1, 2'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bit          ps, pp, fl;
      logic [1:0]  pw, ppw, fw;
      logic [31:0] rpc, pc;
      ps  = ($urandom_range(0, 99) < 40);
      pp  = ($urandom_range(0, 99) < 50);
      fl  = ($urandom_range(0, 99) < 4);
      pw  = 2'($urandom_range(0, 3));
      ppw = 2'($urandom_range(0, 3));
      fw  = 2'($urandom_range(0, 3));
      rpc = 32'($urandom_range(1, 4)) << 8;
      if (stk[ppw].size() > 0 && $urandom_range(0, 99) < 60)
        pc = stk[ppw][stk[ppw].size() - 1].rpc;
      else
        pc = 32'($urandom_range(1, 4)) << 8;
      step(ps, pw, rpc, 32'($urandom()), 8'($urandom()), 8'($urandom()), pp, ppw, pc, fl, fw);
    end

    // Reset while w1 holds four entries and a response is pending.
    idle_step();
    step(1'b0, 2'd0, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
    step(1'b1, 2'd1, 32'h900, 32'h880, 8'h11, 8'h33, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h940, 32'h920, 8'h22, 8'h44, 1'b1, 2'd1, 32'h940, 1'b0, 2'd0);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("arst_empty", 64'(bus.empty_o), 64'hF);
    chk("arst_ovf", 64'(bus.overflow_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/simt_reconv_stack_mw.md
Name: simt_reconv_stack_mw

Overview:
- Parametrised multi-warp SIMT divergence/reconvergence stack for the SM pipeline's simt_stack stage.
- One independent stack per warp, each with a configurable depth. Each divergent branch pushes a {reconvergence PC, jump PC, mask} entry pair.
- Pop requests compare the executing PC against the top-of-stack reconvergence PC and return a registered redirect (PC, mask).
- Adds overflow detection/rejection, per-warp flush on warp end, and per-warp full/empty status.

Parameters:
- NUM_WARP, 4, number of warps; each warp has its own stack.
- NUM_THREAD, 8, threads per warp; sets the mask width.
- DEPTH, 8, entries per warp stack; must be even and >=2.
- PC_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- push_i  in  1  push request (divergent branch)
- push_wid_i  in  clog2(NUM_WARP)  warp id of the push
- push_recon_pc_i  in  PC_WIDTH  reconvergence PC
- push_jump_pc_i  in  PC_WIDTH  branch target PC
- push_new_mask_i  in  NUM_THREAD  taken-path thread mask
- push_thread_mask_i  in  NUM_THREAD  current active mask
- pop_i  in  1  join/pop request
- pop_wid_i  in  clog2(NUM_WARP)  warp id of the pop
- pc_execute_i  in  PC_WIDTH  PC of the join instruction
- flush_i  in  1  warp end: clear the stack of flush_wid_i
- flush_wid_i  in  clog2(NUM_WARP)  warp to flush
- resp_valid_o  out  1  pop response valid (one cycle after pop_i)
- resp_wid_o  out  clog2(NUM_WARP)  warp of the response
- resp_jump_o  out  1  redirect required
- resp_pc_o  out  PC_WIDTH  redirect PC (0 when resp_jump_o=0)
- resp_mask_o  out  NUM_THREAD  new active mask (0 when resp_jump_o=0)
- empty_o  out  NUM_WARP  per-warp stack empty
- full_o  out  NUM_WARP  per-warp stack has <2 free entries
- overflow_o  out  NUM_WARP  sticky per-warp overflow flag

Behaviour:
- Reset: all sp=0; all outputs 0 except empty_o=all ones. Entry contents need no reset.
- State per warp: sp, width clog2(DEPTH+1). TOS index = sp-1.
- Entry format: {rpc, jpc, mask}.
- Accepted push (sp<=DEPTH-2), registered:
  - entry[sp] <= {recon, recon, thread_mask} (join entry).
  - entry[sp+1] <= {recon, jump, new_mask}.
  - sp += 2.
- Push with sp>DEPTH-2: rejected, storage and sp unchanged, overflow_o[wid] set (sticky until reset or flush of that warp).
- Pop:
  - Registered response next cycle: resp_valid_o=1 and resp_wid_o=pop_wid_i.
  - resp_jump_o=1 only if sp!=0 and entry[TOS].rpc==pc_execute_i (sampled in the pop cycle). Then resp_pc_o=entry[TOS].jpc, resp_mask_o=entry[TOS].mask, and sp -= 1 in the same edge.
  - Otherwise resp_jump_o=0, pc/mask=0, sp unchanged.
  - resp_valid_o is a single-cycle pulse per pop; back-to-back pops are allowed, giving one response per cycle.
- Same-cycle events on different warps: all take effect independently.
- Same-cycle events on the same warp, priority flush > push > pop:
  - Suppressed pop still returns a response with resp_jump_o=0.
  - A flushed warp's pop response also has resp_jump_o=0.
- Flush: sp <= 0, overflow_o[wid] <= 0; takes effect at the next edge.
- Status flags are combinational from the registered sp: empty_o[w]=(sp==0), full_o[w]=(sp>DEPTH-2).
- No wrap-around: sp never exceeds DEPTH and never underflows, since a pop requires sp!=0.
- Async reset mid-operation clears everything immediately; a pending response is dropped.

Decomposition:
- Shared package (define include): NUM_WARP, NUM_THREAD, DEPTH, PC_WIDTH defaults; entry field widths; ENTRY_W = 2*PC_WIDTH+NUM_THREAD.
- Natural sub-module: simt_stack_bank, one warp's stack (storage, sp, push/pop/flush, TOS read, overflow), instantiated NUM_WARP times by generate.
- Top level handles: wid decode, same-warp priority, TOS mux by pop_wid_i, response register.

Test Plan:
- Reset, then pop warp0 with pc=0x100 -> next cycle resp_valid=1, jump=0, pc=0, mask=0; empty_o=4'hF.
- Push w1 (recon=0x200, jump=0x180, new=0x0F, thr=0xFF) -> empty_o[1]=0. Pop w1 pc=0x200 -> jump=1, pc=0x180, mask=0x0F. Pop w1 pc=0x200 again -> jump=1, pc=0x200, mask=0xFF. Then empty_o[1]=1.
- DEPTH=8: 4 pushes on w2 -> full_o[2]=1. 5th push -> rejected, overflow_o[2]=1, TOS still the 4th push's values. Flush w2 -> empty_o[2]=1, overflow_o[2]=0.
- Pop w0 with pc mismatch (TOS rpc=0x300, pc=0x304) -> jump=0, sp unchanged.
- Same cycle push w0 and pop w3 -> both performed. Same cycle push and pop on w1 -> push done, pop response jump=0.
- Assert rst_n=0 while a w1 stack holds 4 entries -> all empty, resp_valid_o=0 immediately.
